// File: rtl/seg_pipe_ctrl_if.sv
// Hazard-unit bundle between the pipeline datapath and seg_pipe_ctrl.
// The master modport is the datapath side; the slave modport is the controller.
interface seg_pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1D, Rs2D;
  logic [4:0]       Rs1E, Rs2E, RdE;
  logic [4:0]       RdM, RdW;
  logic [1:0]       RegReadE;
  logic [2:0]       RegWriteM, RegWriteW;
  logic             MemToRegE;
  logic             JalD;
  logic             MispredE;
  logic             DCacheMiss;
  logic             StallF, StallD, StallE, StallM, StallW;
  logic             FlushD, FlushE, FlushM, FlushW;
  logic [1:0]       Forward1E, Forward2E;
  logic [CNT_W-1:0] MispredCnt, StallCnt;
  logic             Timeout;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegReadE, RegWriteM, RegWriteW,
           MemToRegE, JalD, MispredE, DCacheMiss,
    input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM, FlushW,
           Forward1E, Forward2E, MispredCnt, StallCnt, Timeout
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegReadE, RegWriteM, RegWriteW,
           MemToRegE, JalD, MispredE, DCacheMiss,
    output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM, FlushW,
           Forward1E, Forward2E, MispredCnt, StallCnt, Timeout
  );
endinterface

// File: rtl/seg_pipe_ctrl.sv
// Five-stage pipeline hazard controller: stall/flush priority, operand forwarding,
// D-cache miss wait FSM with watchdog, and saturating statistics counters.
module seg_pipe_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic           clk,
  input  logic           rst,
  seg_pipe_ctrl_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {RUN, WAIT} state_t;

  state_t           r_state, w_state_next;
  logic [WW-1:0]    r_wait_cnt, w_wait_next;
  logic [CNT_W-1:0] r_mispred_cnt, r_stall_cnt;
  logic             r_timeout;

  logic w_stall_f, w_stall_d, w_stall_e, w_stall_m, w_stall_w;
  logic w_flush_d, w_flush_e, w_flush_m, w_flush_w;
  logic w_mispred_flush;
  logic w_load_use;

  // MEM result wins over WB when both stages target the same source register.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                         input logic [2:0] wr_m, input logic [4:0] rd_m,
                                         input logic [2:0] wr_w, input logic [4:0] rd_w);
    if (used && (wr_m != 3'd0) && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (used && (wr_w != 3'd0) && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign w_load_use = bus.MemToRegE && (bus.RdE != 5'd0) &&
                      ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

  always_comb begin
    w_state_next    = r_state;
    w_stall_f       = 1'b0;
    w_stall_d       = 1'b0;
    w_stall_e       = 1'b0;
    w_stall_m       = 1'b0;
    w_stall_w       = 1'b0;
    w_flush_d       = 1'b0;
    w_flush_e       = 1'b0;
    w_flush_m       = 1'b0;
    w_flush_w       = 1'b0;
    w_mispred_flush = 1'b0;

    case (r_state)
      RUN:     if (bus.DCacheMiss)  w_state_next = WAIT;
      WAIT:    if (!bus.DCacheMiss) w_state_next = RUN;
      default: w_state_next = RUN;
    endcase

    // The exit cycle of WAIT has DCacheMiss=0, so a held mispredict flushes then.
    if (bus.DCacheMiss) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
      w_stall_w = 1'b1;
    end else if (bus.MispredE) begin
      w_flush_d       = 1'b1;
      w_flush_e       = 1'b1;
      w_mispred_flush = 1'b1;
    end else if (w_load_use) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (bus.JalD) begin
      w_flush_d = 1'b1;
    end
  end

  always_comb begin
    w_wait_next = r_wait_cnt;
    if (w_state_next == RUN)
      w_wait_next = '0;
    else if ((r_state == WAIT) && (r_wait_cnt != WW'(MAX_WAIT)))
      w_wait_next = r_wait_cnt + WW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_mispred_cnt <= '0;
      r_stall_cnt   <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
      if (w_wait_next == WW'(MAX_WAIT))
        r_timeout <= 1'b1;
      if (w_mispred_flush && (r_mispred_cnt != '1))
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      if (w_stall_f && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.StallF     = w_stall_f;
  assign bus.StallD     = w_stall_d;
  assign bus.StallE     = w_stall_e;
  assign bus.StallM     = w_stall_m;
  assign bus.StallW     = w_stall_w;
  assign bus.FlushD     = w_flush_d;
  assign bus.FlushE     = w_flush_e;
  assign bus.FlushM     = w_flush_m;
  assign bus.FlushW     = w_flush_w;
  assign bus.Forward1E  = fwd_sel(bus.RegReadE[1], bus.Rs1E, bus.RegWriteM, bus.RdM,
                                  bus.RegWriteW, bus.RdW);
  assign bus.Forward2E  = fwd_sel(bus.RegReadE[0], bus.Rs2E, bus.RegWriteM, bus.RdM,
                                  bus.RegWriteW, bus.RdW);
  assign bus.MispredCnt = r_mispred_cnt;
  assign bus.StallCnt   = r_stall_cnt;
  assign bus.Timeout    = r_timeout;
endmodule

// File: doc/seg_pipe_ctrl.md
SEG_PIPE_CTRL -- requirements
Module: seg_pipe_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the statistics counters.
REQ-002 Parameter MAX_WAIT, default 64: limit on miss-wait cycles before the timeout flag sets.
REQ-003 clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 Rs1D, Rs2D  in  5 each  ID-stage source registers.
REQ-006 Rs1E, Rs2E, RdE  in  5 each  EX-stage sources and destination.
REQ-007 RdM, RdW  in  5 each  MEM/WB destinations.
REQ-008 RegReadE  in  2  bit1 = rs1 used, bit0 = rs2 used.
REQ-009 RegWriteM, RegWriteW  in  3 each  nonzero = stage writes Rd.
REQ-010 MemToRegE  in  1  EX instruction is a load.
REQ-011 JalD  in  1  JAL decoded in ID.
REQ-012 MispredE  in  1  EX branch/JALR resolved target differs from predicted PC.
REQ-013 DCacheMiss  in  1  data memory not ready.
REQ-014 StallF, StallD, StallE, StallM, StallW  out  1 each  hold the segment register (en = !Stall).
REQ-015 FlushD, FlushE, FlushM, FlushW  out  1 each  clear the segment register.
REQ-016 Forward1E, Forward2E  out  2 each  00 = register file, 10 = MEM result, 01 = WB result.
REQ-017 MispredCnt, StallCnt  out  CNT_W each  statistics counters.
REQ-018 Timeout  out  1  sticky miss-watchdog flag.

Function
REQ-019 The FSM SHALL have states RUN and WAIT.
REQ-020 RUN -> WAIT when DCacheMiss=1; WAIT -> RUN on the first cycle that DCacheMiss=0.
REQ-021 Stalls and flushes SHALL be combinational from state and inputs, with priority: miss > mispredict > load-use > JAL.
REQ-022 Miss: in RUN with DCacheMiss=1, or in WAIT with DCacheMiss=1, all Stall*=1 and all Flush*=0.
REQ-023 Mispredict (no miss, MispredE=1): FlushD=1, FlushE=1, all stalls 0.
REQ-024 Load-use (no miss, no mispredict): when MemToRegE=1, RdE!=0 and RdE equals Rs1D or Rs2D, then StallF=1, StallD=1, FlushE=1.
REQ-025 JAL (none of the above, JalD=1): FlushD=1 only.
REQ-026 Otherwise all Stall* and Flush* outputs SHALL be 0.
REQ-027 In the WAIT->RUN exit cycle (DCacheMiss=0), the non-miss rules (REQ-023 to REQ-026) SHALL apply normally, so a MispredE held across the miss flushes then.
REQ-028 Forward1E = 10 when RegReadE[1], RegWriteM!=0, RdM!=0 and RdM==Rs1E.
REQ-029 Forward1E = 01 when the MEM condition fails and the same condition holds for WB (RegWriteW, RdW).
REQ-030 Forward1E = 00 otherwise.
REQ-031 Forward2E SHALL follow REQ-028 to REQ-030 using Rs2E and RegReadE[0]; MEM SHALL take precedence over WB.
REQ-032 Forwarding SHALL be independent of the FSM state.
REQ-033 MispredCnt SHALL increment on each cycle in which the REQ-023 flush is issued.
REQ-034 StallCnt SHALL increment on each cycle with StallF=1.
REQ-035 Both counters SHALL saturate at all-ones and never wrap.
REQ-036 A wait counter SHALL count consecutive WAIT cycles and clear on RUN entry.
REQ-037 When the wait counter reaches MAX_WAIT, Timeout SHALL set and remain 1 until rst; the FSM continues waiting.

Reset
REQ-038 While rst=1, regardless of clk: state=RUN; wait counter, MispredCnt, StallCnt and Timeout = 0.
REQ-039 Combinational outputs SHALL follow REQ-019 to REQ-032 from the reset state during reset.
REQ-040 rst asserted mid-WAIT SHALL return the FSM to RUN immediately; all stalls drop if DCacheMiss=0.

Verification
REQ-041 Load-use: MemToRegE=1, RdE=5, Rs2D=5 -> StallF=StallD=FlushE=1 for one cycle; StallCnt goes 0 -> 1.
REQ-042 Forward priority: RdM=RdW=3, Rs1E=3, RegReadE=10, RegWriteM=RegWriteW=1 -> Forward1E=10, Forward2E=00; with RdM=0 -> Forward1E=01.
REQ-043 Miss with pending mispredict: DCacheMiss=1 for 4 cycles with MispredE=1 -> all stalls 1 and no flushes for 4 cycles; then DCacheMiss=0 -> FlushD=FlushE=1 in one cycle; MispredCnt=1, StallCnt=4.
REQ-044 Watchdog: MAX_WAIT=8, DCacheMiss held for 10 cycles -> Timeout rises after the 8th WAIT cycle; stays 1 after the miss clears until rst.
REQ-045 Saturation: CNT_W=4, stalls held for 20 cycles -> StallCnt stops at 15.
REQ-046 Async reset: pulse rst between clock edges during WAIT -> state RUN, counters and Timeout 0 before the next edge.
